// File: rtl/apb_nslave_if.sv
// APB bus bundle between one master and NSLV slaves; every slave's
// read data, ready and error come back side by side.
interface apb_nslave_if #(
   parameter int DW   = 8,
   parameter int AW   = 4,
   parameter int NSLV = 4
) ();
   logic [NSLV-1:0]    psel;
   logic               penable;
   logic               pwrite;
   logic [AW-1:0]      paddr;
   logic [DW-1:0]      pwdata;
   logic [NSLV*DW-1:0] prdata;
   logic [NSLV-1:0]    pready;
   logic [NSLV-1:0]    pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_nslave_master.sv
// Single-command APB master fanning out to NSLV slaves, with per-slave
// wait states, error return and an ACCESS-phase timeout.
module apb_nslave_master #(
   parameter int DW      = 8,
   parameter int AW      = 4,
   parameter int NSLV    = 4,
   parameter int SEL_W   = 2,
   parameter int TIMEOUT = 16
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic             newd,
   input  logic             wr,
   input  logic [SEL_W-1:0] slv_addr_in,
   input  logic [AW-1:0]    addrin,
   input  logic [DW-1:0]    datain,
   output logic             busy,
   output logic             done,
   output logic             slverr_o,
   output logic [DW-1:0]    dataout,
   apb_nslave_if.master     apb
);
   localparam int            CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_ERR    = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             slverr_q, slverr_d;
   logic [DW-1:0]    dataout_q, dataout_d;
   logic [NSLV-1:0]  psel_q, psel_d;
   logic             penable_q, penable_d;
   logic             pwrite_q, pwrite_d;
   logic [AW-1:0]    paddr_q, paddr_d;
   logic [DW-1:0]    pwdata_q, pwdata_d;

   logic [NSLV-1:0]  dec_sel;
   logic             rdy_sel;
   logic             err_sel;
   logic [DW-1:0]    rdata_sel;

   // Decode the incoming index and mux only the latched slave's responses.
   always_comb begin
      dec_sel   = '0;
      rdy_sel   = 1'b0;
      err_sel   = 1'b0;
      rdata_sel = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (slv_addr_in == SEL_W'(k)) dec_sel[k] = 1'b1;
         if (sel_q == SEL_W'(k)) begin
            rdy_sel   = apb.pready[k];
            err_sel   = apb.pslverr[k];
            rdata_sel = apb.prdata[k*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      slverr_d  = slverr_q;
      dataout_d = dataout_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      case (state_q)
         ST_IDLE: begin
            if (newd) begin
               pwrite_d = wr;
               paddr_d  = addrin;
               pwdata_d = datain;
               sel_d    = slv_addr_in;
               // An index beyond NSLV decodes to no select line at all.
               if (|dec_sel) begin
                  state_d = ST_SETUP;
                  cnt_d   = '0;
                  psel_d  = dec_sel;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            if (rdy_sel) begin
               state_d   = ST_IDLE;
               done_d    = 1'b1;
               slverr_d  = err_sel;
               psel_d    = '0;
               penable_d = 1'b0;
               if (!pwrite_q && !err_sel) dataout_d = rdata_sel;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_IDLE;
               done_d    = 1'b1;
               slverr_d  = 1'b1;
               psel_d    = '0;
               penable_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            slverr_d = 1'b1;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         slverr_q  <= 1'b0;
         dataout_q <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         slverr_q  <= slverr_d;
         dataout_q <= dataout_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign slverr_o    = slverr_q;
   assign dataout     = dataout_q;
   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.pwrite  = pwrite_q;
   assign apb.paddr   = paddr_q;
   assign apb.pwdata  = pwdata_q;
endmodule

// File: tb/tb_apb_nslave_master.sv
// Scoreboard bench for apb_nslave_master: a 4-slave instance for the main
// transfers and a 3-slave instance for the out-of-range index path.
module tb_apb_nslave_master;
   logic       pclk;
   logic       presetn;
   logic       newd, wr;
   logic [1:0] slv;
   logic [3:0] addrin;
   logic [7:0] datain;
   logic       busy, done, slverr_o;
   logic [7:0] dataout;

   logic       newd3;
   logic [1:0] slv3;
   logic       busy3, done3, slverr3;
   logic [7:0] dout3;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic       err;
      logic [7:0] dout;
      int         at_cyc;
      int         en_cycles;
      logic [3:0] psel;
   } item_t;
   item_t sb[$];

   apb_nslave_if #(.DW(8), .AW(4), .NSLV(4)) bus ();
   apb_nslave_if #(.DW(8), .AW(4), .NSLV(3)) bus3 ();

   apb_nslave_master #(.DW(8), .AW(4), .NSLV(4), .SEL_W(2), .TIMEOUT(16)) u_dut (
      .pclk(pclk), .presetn(presetn), .newd(newd), .wr(wr), .slv_addr_in(slv),
      .addrin(addrin), .datain(datain), .busy(busy), .done(done),
      .slverr_o(slverr_o), .dataout(dataout), .apb(bus.master)
   );

   apb_nslave_master #(.DW(8), .AW(4), .NSLV(3), .SEL_W(2), .TIMEOUT(16)) u_dut3 (
      .pclk(pclk), .presetn(presetn), .newd(newd3), .wr(wr), .slv_addr_in(slv3),
      .addrin(addrin), .datain(datain), .busy(busy3), .done(done3),
      .slverr_o(slverr3), .dataout(dout3), .apb(bus3.master)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: accumulate bus activity, pop and compare whenever done fires.
   int         en_cnt;
   logic [3:0] psel_seen;
   always @(negedge pclk) begin
      item_t it;
      if (!presetn) begin
         en_cnt    = 0;
         psel_seen = '0;
      end else begin
         psel_seen = psel_seen | bus.psel;
         if (bus.penable) en_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done at cycle %0d with empty scoreboard", cyc);
            end else begin
               it = sb.pop_front();
               chk("done_cycle", cyc, it.at_cyc);
               chk("slverr", {31'd0, slverr_o}, {31'd0, it.err});
               chk("dataout", {24'd0, dataout}, {24'd0, it.dout});
               chk("penable_cycles", en_cnt, it.en_cycles);
               chk("psel_seen", {28'd0, psel_seen}, {28'd0, it.psel});
            end
            chk("bus_idle_at_done", {27'd0, bus.psel, bus.penable}, 32'd0);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            en_cnt    = 0;
            psel_seen = '0;
         end
      end
   end

   task automatic issue(input logic w, input logic [1:0] s, input logic [3:0] a,
                        input logic [7:0] d, input bit push, input logic e_err,
                        input logic [7:0] e_dout, input int lat, input int e_en,
                        input logic [3:0] e_psel);
      item_t it;
      newd = 1'b1; wr = w; slv = s; addrin = a; datain = d;
      if (push) begin
         it.err = e_err; it.dout = e_dout; it.at_cyc = cyc + lat;
         it.en_cycles = e_en; it.psel = e_psel;
         sb.push_back(it);
      end
      @(posedge pclk); #1;
      newd = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && sb.size() > 0; i++) @(posedge pclk);
      #1;
      if (sb.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: %0d transfers still pending", sb.size());
         sb.delete();
      end
      @(posedge pclk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      presetn = 1'b0; newd = 1'b0; wr = 1'b0; slv = '0; addrin = '0; datain = '0;
      newd3 = 1'b0; slv3 = '0;
      bus.pready = 4'b1111; bus.pslverr = 4'b0000;
      bus.prdata = {8'h3C, 8'hA5, 8'h11, 8'h5A};
      bus3.pready = 3'b111; bus3.pslverr = 3'b000; bus3.prdata = '0;
      #22;
      chk("rst_outputs", {busy, done, slverr_o, dataout}, 32'd0);
      chk("rst_bus", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 32'd0);
      @(posedge pclk); #1;
      presetn = 1'b1;
      @(posedge pclk); #1;

      // Zero-wait write to slave 1, with phase-by-phase bus checks.
      issue(1'b1, 2'd1, 4'd3, 8'h0F, 1'b1, 1'b0, 8'h00, 3, 1, 4'b0010);
      @(negedge pclk);
      chk("setup_bus", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
          {4'b0010, 1'b0, 1'b1, 4'd3, 8'h0F});
      chk("setup_busy", {31'd0, busy}, 32'd1);
      @(negedge pclk);
      chk("access_bus", {28'd0, bus.psel, bus.penable}, {27'd0, 4'b0010, 1'b1});
      wait_done();

      // Read slave 2 with three wait states; a newd pulse while busy is dropped.
      bus.pready = 4'b1011;
      issue(1'b0, 2'd2, 4'd5, 8'h00, 1'b1, 1'b0, 8'hA5, 6, 4, 4'b0100);
      @(posedge pclk); #1;
      newd = 1'b1; wr = 1'b1; slv = 2'd1; addrin = 4'hF; datain = 8'hFF;
      @(posedge pclk); #1;
      newd = 1'b0;
      @(posedge pclk);
      @(posedge pclk); #1;
      bus.pready = 4'b1111;
      wait_done();

      // Read slave 3 completing with an error keeps the previous read data.
      bus.pslverr = 4'b1000;
      issue(1'b0, 2'd3, 4'd7, 8'h00, 1'b1, 1'b1, 8'hA5, 3, 1, 4'b1000);
      wait_done();
      bus.pslverr = 4'b0000;

      // Slave 0 never ready: exactly TIMEOUT access cycles, then error.
      bus.pready = 4'b1110;
      issue(1'b0, 2'd0, 4'd1, 8'h00, 1'b1, 1'b1, 8'hA5, 18, 16, 4'b0001);
      wait_done();
      bus.pready = 4'b1111;

      // Good read from slave 0 updates dataout.
      issue(1'b0, 2'd0, 4'd2, 8'h00, 1'b1, 1'b0, 8'h5A, 3, 1, 4'b0001);
      wait_done();

      // Asynchronous reset in the middle of ACCESS.
      bus.pready = 4'b1110;
      issue(1'b0, 2'd0, 4'd4, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 4'b0000);
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      chk("pre_reset_access", {28'd0, bus.psel, bus.penable}, {27'd0, 4'b0001, 1'b1});
      #2;
      presetn = 1'b0;
      #1;
      chk("async_rst_bus", {27'd0, bus.psel, bus.penable}, 32'd0);
      chk("async_rst_status", {busy, done, dataout}, 32'd0);
      @(posedge pclk); #1;
      chk("no_done_after_rst", {31'd0, done}, 32'd0);
      #2;
      presetn = 1'b1;
      bus.pready = 4'b1111;
      @(posedge pclk); #1;
      issue(1'b1, 2'd2, 4'd9, 8'h77, 1'b1, 1'b0, 8'h00, 3, 1, 4'b0100);
      wait_done();

      // Out-of-range index on the 3-slave instance, newd repeated while in ERR.
      newd3 = 1'b1; slv3 = 2'd3;
      @(posedge pclk); #1;
      slv3 = 2'd0;
      chk("err_busy", {31'd0, busy3}, 32'd1);
      chk("err_no_psel", {29'd0, bus3.psel}, 32'd0);
      @(posedge pclk); #1;
      newd3 = 1'b0;
      chk("err_done", {29'd0, done3, slverr3, busy3}, {29'd0, 3'b110});
      chk("err_idle_bus", {28'd0, bus3.psel, bus3.penable}, 32'd0);
      @(posedge pclk); #1;
      chk("err_newd_ignored", {27'd0, bus3.psel, done3, busy3}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
